// File: rtl/uart_rx_fifo_pkg.sv
// ============================================================================
// uart_rx_fifo_pkg : shared UART widths and default RX FIFO sizing
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_rx_fifo_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int RX_FIFO_DEPTH_LOG2 = 4;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
// ============================================================================
// uart_rx_fifo_if : receiver strobe, CPU read port and status of the RX FIFO
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
);

    logic                rx_rdy;
    uart_byte_t          rx_data;
    logic                rx_rdy_clr;
    logic                rd_en;
    uart_byte_t          dout;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overrun;
    logic                ovr_clr;

    modport master (
        output rx_rdy, rx_data, rd_en, ovr_clr,
        input  rx_rdy_clr, dout, empty, full, count, overrun
    );

    modport slave (
        input  rx_rdy, rx_data, rd_en, ovr_clr,
        output rx_rdy_clr, dout, empty, full, count, overrun
    );

endinterface

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// ============================================================================
// uart_byte_fifo : generic first-word-fall-through store with occupancy count
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_byte_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                push_i,
    input  wire logic [DATA_W-1:0]   push_data_i,
    input  wire logic                pop_i,
    output logic      [DATA_W-1:0]   dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic      [DEPTH_LOG2:0] count_o
);

    localparam int                  c_DEPTH    = 2**DEPTH_LOG2;
    localparam int                  c_CW       = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] c_FULL_CNT = c_CW'(c_DEPTH);

    logic [DATA_W-1:0]     mem_q [c_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    // A pop in the same cycle frees a slot, so a push into a full store still lands.
    assign w_pop_ok  = pop_i & ~empty_o;
    assign w_push_ok = push_i & (~full_o | w_pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == c_FULL_CNT);
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo : captures UART receiver bytes into a FIFO, with ack and overrun
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
    input  wire logic      clk_50m,
    input  wire logic      rst_n,
    uart_rx_fifo_if.slave  bus
);

    logic rdy_q;
    logic rx_rdy_clr_q;
    logic overrun_q, overrun_d;
    logic w_wr_req;
    logic w_rd_req;
    logic w_drop;

    // Edge detect gives one request per byte, however long the receiver holds rdy.
    assign w_wr_req = bus.rx_rdy & ~rdy_q;
    assign w_rd_req = bus.rd_en & ~bus.empty;
    assign w_drop   = w_wr_req & bus.full & ~w_rd_req;

    always_comb begin
        overrun_d = overrun_q;
        if (w_drop) begin
            overrun_d = 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q        <= 1'b0;
            rx_rdy_clr_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rdy_q        <= bus.rx_rdy;
            rx_rdy_clr_q <= w_wr_req;
            overrun_q    <= overrun_d;
        end
    end

    uart_byte_fifo #(
        .DATA_W     (UART_DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_store (
        .clk         (clk_50m),
        .rst_n       (rst_n),
        .push_i      (w_wr_req),
        .push_data_i (bus.rx_data),
        .pop_i       (bus.rd_en),
        .dout_o      (bus.dout),
        .empty_o     (bus.empty),
        .full_o      (bus.full),
        .count_o     (bus.count)
    );

    assign bus.rx_rdy_clr = rx_rdy_clr_q;
    assign bus.overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// tb_uart_rx_fifo : directed and randomized checks of uart_rx_fifo against a queue model
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int DL    = RX_FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << DL;
    localparam int CW    = DL + 1;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;

    uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 clk_50m = ~clk_50m;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a byte queue plus the sticky flag and previous rdy level.
    byte unsigned m_q[$];
    bit           m_ovr;
    bit           m_rdy_prev;
    bit           m_clr;

    task automatic idle_inputs();
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        bus.rd_en   = 1'b0;
        bus.ovr_clr = 1'b0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovr      = 1'b0;
        m_rdy_prev = 1'b0;
        m_clr      = 1'b0;
    endtask

    task automatic cycle();
        bit new_byte, popping, was_full;
        @(posedge clk_50m);
        new_byte = bus.rx_rdy && !m_rdy_prev;
        popping  = bus.rd_en && (m_q.size() != 0);
        was_full = (m_q.size() == DEPTH);
        if (popping) void'(m_q.pop_front());
        if (new_byte && (!was_full || popping)) m_q.push_back(bus.rx_data);
        if (new_byte && was_full && !popping) m_ovr = 1'b1;
        else if (bus.ovr_clr)                 m_ovr = 1'b0;
        m_clr      = new_byte;
        m_rdy_prev = bus.rx_rdy;
        #1;
    endtask

    task automatic push_byte(input byte unsigned b);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        cycle();
        bus.rx_rdy  = 1'b0;
        cycle();
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #25;
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
        n_checks++; if (bus.rx_rdy_clr !== 1'b0) begin n_fail++; $display("FAIL reset_clr: got %b expected 0", bus.rx_rdy_clr); end
        @(negedge clk_50m);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_single_capture();
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'hA5;
        cycle();
        bus.rx_rdy  = 1'b0;
        n_checks++; if (bus.rx_rdy_clr !== 1'b1) begin n_fail++; $display("FAIL single_clr: got %b expected 1", bus.rx_rdy_clr); end
        n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", bus.empty); end
        n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL single_count: got %0d expected 1", bus.count); end
        n_checks++; if (bus.dout !== 8'hA5) begin n_fail++; $display("FAIL single_dout: got %h expected a5", bus.dout); end
        cycle();
        n_checks++; if (bus.rx_rdy_clr !== 1'b0) begin n_fail++; $display("FAIL single_clr_drop: got %b expected 0", bus.rx_rdy_clr); end
        pop_one();
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL single_pop_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_held_rdy();
        int clr_seen = 0;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (bus.rx_rdy_clr === 1'b1) clr_seen++;
        end
        bus.rx_rdy = 1'b0;
        n_checks++; if (clr_seen != 1) begin n_fail++; $display("FAIL held_clr_cycles: got %0d expected 1", clr_seen); end
        n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL held_count: got %0d expected 1", bus.count); end
        n_checks++; if (bus.dout !== 8'h3C) begin n_fail++; $display("FAIL held_dout: got %h expected 3c", bus.dout); end
        cycle();
        pop_one();
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL held_pop_count: got %0d expected 0", bus.count); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < DEPTH; i++) push_byte(byte'(i));
        n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", bus.full); end
        n_checks++; if (bus.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", bus.count, DEPTH); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovr: got %b expected 0", bus.overrun); end
        push_byte(8'hFF);
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL drop_overrun: got %b expected 1", bus.overrun); end
        n_checks++; if (bus.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL drop_count: got %0d expected %0d", bus.count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (bus.dout !== 8'(i)) begin n_fail++; $display("FAIL drain_order: got %h expected %h", bus.dout, 8'(i)); end
            pop_one();
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", bus.empty); end
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", bus.overrun); end
        bus.ovr_clr = 1'b1;
        cycle();
        bus.ovr_clr = 1'b0;
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_full_push_pop();
        byte unsigned last;
        for (int i = 0; i < DEPTH; i++) push_byte(byte'(8'h20 + i));
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h55;
        bus.rd_en   = 1'b1;
        cycle();
        bus.rx_rdy = 1'b0;
        bus.rd_en  = 1'b0;
        n_checks++; if (bus.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fullpp_count: got %0d expected %0d", bus.count, DEPTH); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL fullpp_overrun: got %b expected 0", bus.overrun); end
        n_checks++; if (bus.dout !== 8'h21) begin n_fail++; $display("FAIL fullpp_head: got %h expected 21", bus.dout); end
        cycle();
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            last = bus.dout;
            pop_one();
        end
        n_checks++; if (last !== 8'h55) begin n_fail++; $display("FAIL fullpp_last: got %h expected 55", last); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fullpp_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_empty_pop();
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        bus.rd_en = 1'b0;
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL emptypop_count: got %0d expected 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL emptypop_empty: got %b expected 1", bus.empty); end
        push_byte(8'h12);
        n_checks++; if (bus.dout !== 8'h12) begin n_fail++; $display("FAIL emptypop_dout: got %h expected 12", bus.dout); end
        n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL emptypop_push_count: got %0d expected 1", bus.count); end
        pop_one();
    endtask

    task automatic test_overrun_clear_and_reset();
        for (int i = 0; i < DEPTH; i++) push_byte(byte'(i * 3));
        push_byte(8'hAA);
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr2_set: got %b expected 1", bus.overrun); end
        bus.ovr_clr = 1'b1;
        cycle();
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr2_clear: got %b expected 0", bus.overrun); end
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'hBB;
        cycle();
        bus.rx_rdy  = 1'b0;
        bus.ovr_clr = 1'b0;
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr2_drop_wins: got %b expected 1", bus.overrun); end
        cycle();
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h77;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL async_rst_count: got %0d expected 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL async_rst_empty: got %b expected 1", bus.empty); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL async_rst_overrun: got %b expected 0", bus.overrun); end
        idle_inputs();
        model_reset();
        @(negedge clk_50m);
        rst_n = 1'b1;
        cycle();
        n_checks++; if (bus.rx_rdy_clr !== 1'b0) begin n_fail++; $display("FAIL async_rst_no_clr: got %b expected 0", bus.rx_rdy_clr); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL async_rst_post_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_random();
        int rd_pct;
        for (int i = 0; i < 600; i++) begin
            rd_pct      = (i < 300) ? 15 : 70;
            bus.rx_rdy  = ($urandom_range(0, 99) < 50);
            bus.rx_data = 8'($urandom);
            bus.rd_en   = ($urandom_range(0, 99) < rd_pct);
            bus.ovr_clr = ($urandom_range(0, 99) < 5);
            cycle();
            n_checks++; if (bus.count !== CW'(m_q.size())) begin n_fail++; $display("FAIL rand_count: cyc %0d got %0d expected %0d", i, bus.count, m_q.size()); end
            n_checks++; if (bus.empty !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rand_empty: cyc %0d got %b expected %b", i, bus.empty, m_q.size() == 0); end
            n_checks++; if (bus.full !== (m_q.size() == DEPTH)) begin n_fail++; $display("FAIL rand_full: cyc %0d got %b expected %b", i, bus.full, m_q.size() == DEPTH); end
            n_checks++; if (bus.overrun !== m_ovr) begin n_fail++; $display("FAIL rand_overrun: cyc %0d got %b expected %b", i, bus.overrun, m_ovr); end
            n_checks++; if (bus.rx_rdy_clr !== m_clr) begin n_fail++; $display("FAIL rand_clr: cyc %0d got %b expected %b", i, bus.rx_rdy_clr, m_clr); end
            if (m_q.size() != 0) begin
                n_checks++; if (bus.dout !== m_q[0]) begin n_fail++; $display("FAIL rand_dout: cyc %0d got %h expected %h", i, bus.dout, m_q[0]); end
            end
        end
        idle_inputs();
        cycle();
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_held_rdy();
        test_fill_overrun();
        test_full_push_pop();
        test_empty_pop();
        test_overrun_clear_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
